store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 30 +++
 rtl/store_buffer.sv | 106 ++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Core-side store/load handshake and data-memory port of the store buffer.
// The buffer uses the slave view; the core (or a bench) uses the master view.
interface store_buffer_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [63:0] st_data;
  logic        st_ready;
  logic        st_err;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [63:0] ld_data;
  logic [31:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic        mem_wr_enable;
  logic        mem_rd_enable;
  logic [63:0] mem_rd_data;
  logic        empty;

  modport slave (
    input  st_valid, st_addr, st_data, ld_req, ld_addr, mem_rd_data,
    output st_ready, st_err, ld_data, mem_addr, mem_wr_data,
           mem_wr_enable, mem_rd_enable, empty
  );

  modport master (
    output st_valid, st_addr, st_data, ld_req, ld_addr, mem_rd_data,
    input  st_ready, st_err, ld_data, mem_addr, mem_wr_data,
           mem_wr_enable, mem_rd_enable, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer: queues core stores, drains them to data memory when
// the port is free of loads, and forwards the youngest matching store to loads.
module store_buffer #(
  parameter int DEPTH    = 4,
  parameter int ROM_SIZE = 4
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  bus
);
  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL     = (AW + 1)'(DEPTH);
  localparam logic [28:0] ROM_WORDS = 29'(ROM_SIZE);

  logic [AW-1:0]    head_reg;
  logic [AW-1:0]    tail_reg;
  logic [AW:0]      count_reg;
  logic [DEPTH-1:0] valid_reg;
  logic             err_reg;

  logic [28:0] word_mem [DEPTH];
  logic [63:0] data_mem [DEPTH];

  logic             rom_hit;
  logic             push;
  logic             drain;
  logic [DEPTH-1:0] hit;
  logic [AW-1:0]    scan_idx;
  logic             fwd_found;
  logic [63:0]      fwd_data;

  assign rom_hit      = bus.st_addr[31:3] < ROM_WORDS;
  assign bus.st_ready = count_reg < FULL;
  assign push         = bus.st_valid && bus.st_ready && !rom_hit;
  assign drain        = !bus.ld_req && (count_reg != '0);
  assign bus.empty    = (count_reg == '0);
  assign bus.st_err   = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      err_reg   <= bus.st_valid && rom_hit;
      count_reg <= count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, drain};
      // head and tail only coincide when empty (no drain) or full (no push)
      if (drain) begin
        head_reg            <= head_reg + 1'b1;
        valid_reg[head_reg] <= 1'b0;
      end
      if (push) begin
        tail_reg            <= tail_reg + 1'b1;
        valid_reg[tail_reg] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[tail_reg] <= bus.st_addr[31:3];
      data_mem[tail_reg] <= bus.st_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign hit[gi] = valid_reg[gi] && (word_mem[gi] == bus.ld_addr[31:3]);
  end

  // Walk oldest to youngest so the last hit seen is the youngest store.
  always_comb begin
    fwd_found = 1'b0;
    fwd_data  = '0;
    scan_idx  = head_reg;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_reg + AW'(i);
      if (hit[scan_idx]) begin
        fwd_found = 1'b1;
        fwd_data  = data_mem[scan_idx];
      end
    end
  end

  always_comb begin
    bus.ld_data = '0;
    if (bus.ld_req)
      bus.ld_data = fwd_found ? fwd_data : bus.mem_rd_data;
  end

  always_comb begin
    bus.mem_addr      = '0;
    bus.mem_wr_data   = '0;
    bus.mem_wr_enable = 1'b0;
    bus.mem_rd_enable = 1'b0;
    if (bus.ld_req) begin
      bus.mem_addr      = bus.ld_addr;
      bus.mem_rd_enable = 1'b1;
    end else if (count_reg != '0) begin
      bus.mem_addr      = {word_mem[head_reg], 3'b000};
      bus.mem_wr_data   = data_mem[head_reg];
      bus.mem_wr_enable = 1'b1;
    end
  end
endmodule
